// File: rtl/useq_irqc_if.sv
// useq_irqc_if: core/host side bundle of the useq interrupt controller.
// Carries the config register port and the req/vector + ack/done handshake.
//
// Ports (signals):
//   cfg_we, cfg_re, cfg_addr, cfg_wdata  -> controller (register access)
//   cfg_rdata                            <- controller (registered read data)
//   irq_req, irq_id, irq_vect            <- controller (request to core)
//   irq_ack, irq_done                    -> controller (core handshake)
//   in_service                           <- controller (ISR active)
// Modports: master = core/host side, slave = controller side.
interface useq_irqc_if #(
    parameter int N_CH = 8,
    parameter int VW   = 8,
    parameter int IDW  = 4
);
    logic            cfg_we;
    logic            cfg_re;
    logic [1:0]      cfg_addr;
    logic [N_CH-1:0] cfg_wdata;
    logic [N_CH-1:0] cfg_rdata;
    logic            irq_req;
    logic [IDW-1:0]  irq_id;
    logic [VW-1:0]   irq_vect;
    logic            irq_ack;
    logic            irq_done;
    logic            in_service;

    modport master (
        output cfg_we,
        output cfg_re,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata,
        input  irq_req,
        input  irq_id,
        input  irq_vect,
        output irq_ack,
        output irq_done,
        input  in_service
    );

    modport slave (
        input  cfg_we,
        input  cfg_re,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata,
        output irq_req,
        output irq_id,
        output irq_vect,
        input  irq_ack,
        input  irq_done,
        output in_service
    );
endinterface

// File: rtl/useq_irqc.sv
// useq_irqc: N_CH-channel interrupt controller for the useq microsequencer.
// Synchronises raw request lines, latches edge/level pendings, and presents
// the lowest-index enabled pending as a request/vector with ack/done.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   i_irq  - raw asynchronous request lines (N_CH)
//   bus    - useq_irqc_if.slave: config registers + core handshake
//            cfg_addr: 0=ENABLE 1=MODE(1=edge) 2=POLARITY(1=active-low)
//                      3=PENDING (write-1-to-clear, edge bits only)
module useq_irqc #(
    parameter int              N_CH        = 8,
    parameter int              VW          = 8,
    parameter logic [VW-1:0]   VECT_BASE   = 'hF0,
    parameter int              VECT_STRIDE = 2,
    parameter int              SYNC_STAGES = 2,
    parameter int              IDW         = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] i_irq,
    useq_irqc_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [1:0] A_ENABLE  = 2'd0;
    localparam logic [1:0] A_MODE    = 2'd1;
    localparam logic [1:0] A_POL     = 2'd2;
    localparam logic [1:0] A_PENDING = 2'd3;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [N_CH-1:0] r_sync [SYNC_STAGES];
    logic [N_CH-1:0] r_en;
    logic [N_CH-1:0] r_mode;
    logic [N_CH-1:0] r_pol;
    logic [N_CH-1:0] r_sprev;
    logic [N_CH-1:0] r_pend;
    logic [N_CH-1:0] r_rdata;
    logic [IDW-1:0]  r_id;
    logic [VW-1:0]   r_vect;
    logic            r_req;
    logic            r_insvc;

    logic [N_CH-1:0] w_sync;
    logic [N_CH-1:0] w_s;
    logic [N_CH-1:0] w_rise;
    logic [N_CH-1:0] w_elig;
    logic [N_CH-1:0] w_id_oh;
    logic [N_CH-1:0] w_w1c;
    logic [N_CH-1:0] w_clr;
    logic [N_CH-1:0] w_pend_nxt;
    logic [IDW-1:0]  w_win;
    logic [VW-1:0]   w_win_vect;
    logic            w_any;
    logic            w_lat_elig;
    logic            w_take;
    logic            w_wr_en;
    logic            w_wr_mode;
    logic            w_wr_pol;
    logic            w_wr_pend;

    assign w_wr_en   = bus.cfg_we && (bus.cfg_addr == A_ENABLE);
    assign w_wr_mode = bus.cfg_we && (bus.cfg_addr == A_MODE);
    assign w_wr_pol  = bus.cfg_we && (bus.cfg_addr == A_POL);
    assign w_wr_pend = bus.cfg_we && (bus.cfg_addr == A_PENDING);

    // Input synchroniser chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_s    = w_sync ^ r_pol;
    assign w_rise = w_s & ~r_sprev;
    assign w_elig = r_pend & r_en;

    // A polarity change reloads s_prev with the new adjusted level so the
    // flip itself is never mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sprev <= '0;
        end else if (w_wr_pol) begin
            r_sprev <= w_sync ^ bus.cfg_wdata;
        end else begin
            r_sprev <= w_s;
        end
    end

    // Lowest index wins: scan downward so the last hit is the lowest.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = IDW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign w_win_vect = VECT_BASE + VW'(VECT_STRIDE) * VW'(w_win);

    always_comb begin
        w_id_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_id_oh[i] = (r_id == IDW'(i));
        end
    end

    assign w_lat_elig = |(w_elig & w_id_oh);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state; ack beats a same-cycle loss of eligibility
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    w_state_nxt = ST_ACTIVE;
                    w_take      = 1'b1;
                end else if (!w_lat_elig) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (bus.irq_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request outputs registered from the next state so they track r_state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req   <= 1'b0;
            r_insvc <= 1'b0;
        end else begin
            r_req   <= (w_state_nxt == ST_REQ);
            r_insvc <= (w_state_nxt == ST_ACTIVE);
        end
    end

    // id/vector only move on the IDLE->REQ transition, frozen otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id   <= '0;
            r_vect <= '0;
        end else if (r_state == ST_IDLE && w_any) begin
            r_id   <= w_win;
            r_vect <= w_win_vect;
        end
    end

    // Edge bits: sticky, set beats clear. Level bits: follow s directly.
    assign w_w1c      = w_wr_pend ? (bus.cfg_wdata & r_mode) : '0;
    assign w_clr      = w_w1c | (w_take ? (w_id_oh & r_mode) : '0);
    assign w_pend_nxt = (r_mode & (w_rise | (r_pend & ~w_clr)))
                      | (~r_mode & w_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // Config registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en   <= '0;
            r_mode <= '0;
            r_pol  <= '0;
        end else begin
            if (w_wr_en) begin
                r_en <= bus.cfg_wdata;
            end
            if (w_wr_mode) begin
                r_mode <= bus.cfg_wdata;
            end
            if (w_wr_pol) begin
                r_pol <= bus.cfg_wdata;
            end
        end
    end

    // Registered read port, holds its value between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (bus.cfg_re) begin
            case (bus.cfg_addr)
                A_ENABLE:  r_rdata <= r_en;
                A_MODE:    r_rdata <= r_mode;
                A_POL:     r_rdata <= r_pol;
                default:   r_rdata <= r_pend;
            endcase
        end
    end

    assign bus.cfg_rdata  = r_rdata;
    assign bus.irq_req    = r_req;
    assign bus.irq_id     = r_id;
    assign bus.irq_vect   = r_vect;
    assign bus.in_service = r_insvc;

endmodule

// File: tb/tb_useq_irqc.sv
// tb_useq_irqc: scoreboard bench for useq_irqc.
// Stimulus queues expected requests/reads; a monitor pops and compares.
module tb_useq_irqc;

    localparam int N   = 8;
    localparam int VW  = 8;
    localparam int IDW = 4;

    typedef struct {
        int id;
        int vect;
        int cyc;
    } req_t;

    logic         clk;
    logic         rst;
    logic [N-1:0] irq_in;

    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc   = 0;

    req_t         req_q[$];
    logic [N-1:0] rd_q[$];
    logic         rd_seen;
    bit           prev_req;

    useq_irqc_if #(.N_CH(N), .VW(VW), .IDW(IDW)) bus ();

    useq_irqc #(
        .N_CH(N),
        .VW(VW),
        .VECT_BASE(8'hF0),
        .VECT_STRIDE(2),
        .SYNC_STAGES(2),
        .IDW(IDW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_irq(irq_in),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;
    always @(posedge clk) rd_seen <= bus.cfg_re;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int vect_of(input int ch);
        return (240 + 2 * ch) % 256;
    endfunction

    task automatic push_req(input int ch, input int c);
        req_t e;
        e.id   = ch;
        e.vect = vect_of(ch);
        e.cyc  = c;
        req_q.push_back(e);
    endtask

    // Monitor: request rising edges and read data returns
    initial begin
        req_t e;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.irq_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_req: got id=%0d required none",
                             bus.irq_id);
                end else begin
                    e = req_q.pop_front();
                    chk("req_id", 32'(bus.irq_id), e.id);
                    chk("req_vect", 32'(bus.irq_vect), e.vect);
                    if (e.cyc >= 0) chk("req_cycle", cyc, e.cyc);
                end
            end
            prev_req = bus.irq_req;
            if (rd_seen && !rst) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_read: got 0x%0h required none",
                             bus.cfg_rdata);
                end else begin
                    chk("cfg_rdata", 32'(bus.cfg_rdata), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [N-1:0] d);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = a;
        bus.cfg_wdata = d;
        tick();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, input logic [N-1:0] exp);
        rd_q.push_back(exp);
        bus.cfg_re   = 1'b1;
        bus.cfg_addr = a;
        tick();
        bus.cfg_re   = 1'b0;
    endtask

    task automatic wait_req();
        int k = 0;
        while (!bus.irq_req && k < 60) begin
            tick();
            k++;
        end
        chk("req_wait", 32'(bus.irq_req), 1);
    endtask

    task automatic do_ack();
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("ack_insvc", 32'(bus.in_service), 1);
        chk("ack_req_low", 32'(bus.irq_req), 0);
    endtask

    task automatic do_done();
        bus.irq_done = 1'b1;
        tick();
        bus.irq_done = 1'b0;
        chk("done_insvc", 32'(bus.in_service), 0);
    endtask

    task automatic chk_outs_zero(input string nm);
        chk({nm, "_req"}, 32'(bus.irq_req), 0);
        chk({nm, "_insvc"}, 32'(bus.in_service), 0);
        chk({nm, "_id"}, 32'(bus.irq_id), 0);
        chk({nm, "_vect"}, 32'(bus.irq_vect), 0);
        chk({nm, "_rdata"}, 32'(bus.cfg_rdata), 0);
    endtask

    initial begin
        logic [N-1:0] en;
        logic [N-1:0] m;
        int           cnt;
        int           k;
        bit           seen;

        rst           = 1'b1;
        irq_in        = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_re    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
        bus.irq_ack   = 1'b0;
        bus.irq_done  = 1'b0;
        tick(3);
        chk_outs_zero("reset");
        rst = 1'b0;
        tick(2);
        cfg_read(2'd0, 8'h00);
        cfg_read(2'd1, 8'h00);
        cfg_read(2'd2, 8'h00);
        cfg_read(2'd3, 8'h00);

        // Edge ch0: 4-edge latency, ack clears pending
        cfg_write(2'd0, 8'h01);
        cfg_write(2'd1, 8'h01);
        push_req(0, cyc + 4);
        irq_in = 8'h01;
        wait_req();
        do_ack();
        cfg_read(2'd3, 8'h00);
        tick(2);
        do_done();
        irq_in = 8'h00;
        tick(5);

        // Simultaneous ch1/ch2 with enable; priority then 1 idle cycle
        cfg_write(2'd1, 8'hFF);
        push_req(1, cyc + 4);
        push_req(2, -1);
        irq_in = 8'h06;
        cfg_write(2'd0, 8'h06);
        wait_req();
        do_ack();
        tick(3);
        do_done();
        req_q[0].cyc = cyc + 1;
        wait_req();
        do_ack();
        do_done();
        irq_in = 8'h00;
        tick(5);

        // Level ch3: re-request after done, drop when deasserted in REQ
        cfg_write(2'd1, 8'hF7);
        cfg_write(2'd0, 8'h08);
        push_req(3, -1);
        irq_in = 8'h08;
        wait_req();
        do_ack();
        tick(2);
        do_done();
        push_req(3, cyc + 1);
        wait_req();
        irq_in = 8'h00;
        k = 0;
        while (bus.irq_req && k < 10) begin
            tick();
            k++;
        end
        chk("level_drop_req", 32'(bus.irq_req), 0);
        chk("level_drop_insvc", 32'(bus.in_service), 0);
        tick(6);

        // Two ch0 edges during ACTIVE collapse to one pending event
        cfg_write(2'd1, 8'hFF);
        cfg_write(2'd0, 8'h01);
        push_req(0, cyc + 4);
        irq_in = 8'h01;
        wait_req();
        do_ack();
        irq_in = 8'h00; tick(3);
        irq_in = 8'h01; tick(3);
        irq_in = 8'h00; tick(3);
        irq_in = 8'h01; tick(3);
        irq_in = 8'h00; tick(4);
        cfg_read(2'd3, 8'h01);
        do_done();
        push_req(0, cyc + 1);
        wait_req();
        do_ack();
        do_done();
        tick(10);

        // Polarity flip with line high: no spurious edge
        cfg_write(2'd0, 8'h00);
        irq_in = 8'h80;
        tick(5);
        cfg_write(2'd3, 8'hFF);
        cfg_write(2'd2, 8'h80);
        cfg_write(2'd0, 8'h80);
        tick(10);
        cfg_read(2'd3, 8'h00);
        cfg_read(2'd2, 8'h80);
        push_req(7, cyc + 4);
        irq_in = 8'h00;
        wait_req();
        do_ack();
        tick(2);

        // Reset mid-ISR
        rst = 1'b1;
        #1;
        chk_outs_zero("midrst");
        tick(2);
        rst = 1'b0;
        tick();
        cfg_read(2'd0, 8'h00);
        cfg_read(2'd2, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            irq_in = N'($urandom_range(0, 255));
            tick();
            if (bus.irq_req || bus.in_service) seen = 1'b1;
        end
        chk("disabled_no_req", 32'(seen), 0);
        irq_in = 8'h00;
        tick(5);

        // Randomised: edge mode, random enables and simultaneous lines
        cfg_write(2'd1, 8'hFF);
        cfg_write(2'd3, 8'hFF);
        for (int it = 0; it < 25; it++) begin
            en  = N'($urandom_range(0, 255));
            m   = N'($urandom_range(1, 255));
            cnt = 0;
            cfg_write(2'd0, en);
            for (int c = 0; c < N; c++) begin
                if (m[c] && en[c]) begin
                    push_req(c, (cnt == 0) ? cyc + 4 : -1);
                    cnt++;
                end
            end
            irq_in = m;
            for (int s = 0; s < cnt; s++) begin
                wait_req();
                tick($urandom_range(0, 3));
                do_ack();
                tick($urandom_range(0, 4));
                do_done();
            end
            tick(5);
            cfg_read(2'd3, m & ~en);
            irq_in = 8'h00;
            tick(4);
            cfg_write(2'd3, 8'hFF);
            tick(2);
        end

        tick(5);
        chk("sb_req_drain", req_q.size(), 0);
        chk("sb_rd_drain", rd_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/useq_irqc.md
# useq_irqc

Parametrised interrupt controller for the useq microsequencer family, replacing the fixed single-source, edge-only IRQ logic inside the core. It synchronises N_CH external request lines and latches each in a per-channel edge- or level-sensitive pending register. It presents the highest-priority enabled request to the core as a request/vector pair with an ack/done handshake, blocking nesting until the ISR returns. A small register file lets the core or host configure enable, mode, polarity and pending state.

## Interface
- N_CH, 8, number of interrupt channels (1..16)
- VW, 8, vector/address width (matches core mem_addr width)
- VECT_BASE, 8'hF0, vector of channel 0
- VECT_STRIDE, 2, vector spacing between channels
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- IDW, 4, channel-id width (clog2(N_CH), min 1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_irq  in  N_CH  raw asynchronous request lines
- cfg_we  in  1  register write strobe
- cfg_re  in  1  register read strobe
- cfg_addr  in  2  0=ENABLE 1=MODE(1=edge) 2=POLARITY(1=active-low) 3=PENDING
- cfg_wdata  in  N_CH  write data
- cfg_rdata  out  N_CH  read data, registered
- irq_req  out  1  interrupt request to core
- irq_id  out  IDW  channel being requested/serviced
- irq_vect  out  VW  ISR entry address for irq_id
- irq_ack  in  1  core takes the request (1-cycle pulse)
- irq_done  in  1  core returns from ISR (1-cycle pulse)
- in_service  out  1  ISR active

## Operation
- Per channel: s = sync(i_irq) XOR POLARITY. Edge mode: pending set when s & ~s_prev. Level mode: pending = s, continuously; not clearable by ack or W1C.
- Eligible = pending & ENABLE. Priority: lowest index wins.
- FSM IDLE/REQ/ACTIVE:
  - IDLE: any eligible -> REQ; latch irq_id = winner, irq_vect = VECT_BASE + irq_id*VECT_STRIDE (mod 2^VW).
  - REQ: irq_ack -> ACTIVE, clear pending[irq_id] if edge mode. If the latched channel is no longer eligible (disabled, W1C, level deasserted) and no ack -> IDLE. irq_id is frozen in REQ; later higher-priority arrivals do not preempt.
  - ACTIVE: irq_done -> IDLE. No new request while ACTIVE (no nesting); pendings still accumulate.
- irq_ack outside REQ and irq_done outside ACTIVE are ignored.
- PENDING write: write-1-to-clear, edge-mode bits only.
- Same-cycle set and clear of one pending bit (ack or W1C): set wins.
- POLARITY write reloads s_prev with the new polarity-adjusted value, so no spurious edge.
- Edge mode with multiple edges before service: a single pending event (no counting).
- Reset (any time, including mid-ISR): FSM IDLE. All of these are 0: sync chains, s_prev, ENABLE, MODE, POLARITY, pending, irq_req, irq_id, irq_vect, in_service, cfg_rdata.

## Timing
- irq_req = (state==REQ), registered; in_service = (state==ACTIVE), registered.
- Edge latency: the edge of rising clock that first samples a new i_irq level is edge 1. For a channel that is enabled and whose FSM is in IDLE, pending sets at edge SYNC_STAGES+1 and irq_req rises after edge SYNC_STAGES+2 (4 cycles at default).
- irq_ack sampled high in REQ: irq_req low and in_service high after that same edge.
- irq_done sampled in ACTIVE: in_service low after that edge. If another channel is pending, irq_req rises one edge later (1 idle cycle between services).
- irq_id/irq_vect are stable from irq_req rise until the ack edge, and are held through ACTIVE.
- cfg_rdata is valid the cycle after cfg_re and holds otherwise. A config write takes effect on the following edge.

## Test plan
- Reset, ENABLE=0x01, MODE=0x01; i_irq[0] 0->1 -> irq_req high after 4 edges, irq_id=0, irq_vect=0xF0; ack -> in_service=1, PENDING reads 0x00.
- i_irq=0x06 simultaneously with ENABLE=0x06 in edge mode -> irq_id=1, vect=0xF2; after ack and done, one idle cycle, then irq_id=2, vect=0xF4.
- Level mode ch3, held high through done -> immediate re-request. Deassert during REQ with no ack -> irq_req drops, FSM IDLE.
- During ACTIVE on ch0, pulse ch0 twice -> after done, exactly one further request.
- Set POLARITY=0x80 with i_irq[7]=1 -> no request. Drive i_irq[7] 1->0 (ENABLE bit7, edge mode) -> request, vect=0xFE.
- Assert rst during ACTIVE -> all outputs 0 within the reset. After release with ENABLE=0 -> no irq_req for 20 cycles despite toggling inputs.
